ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Byte-wide RAM responder serving the processor's fetch/load/store requests. It is the memory end of the core's instruction/data interface.
- Accepts one request at a time over a valid/ready handshake. Returns read data as a stream of 1 or BURST bytes; performs byte stores in a single cycle.
- Sits between the processor core (initiator) and the program/data RAM array, which it owns.

Parameters:
- RAMSIZE, 64, number of 8-bit RAM locations; valid addresses are 0..RAMSIZE-1.
- ADDRW, 16, request address width.
- BURST, 4, bytes returned for a fetch request (opcode, reg, addr lo, addr hi).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = byte store, 0 = read.
- req_burst  input  1  read only: 1 = BURST-byte fetch, 0 = single-byte load.
- req_addr  input  ADDRW  byte address (first byte of a burst).
- req_wdata  input  8  store data.
- rsp_valid  output  1  read data beat valid.
- rsp_ready  input  1  initiator accepts beat.
- rsp_data  output  8  read data beat.
- rsp_last  output  1  final beat of the current read.
- err  output  1  one-cycle pulse on any out-of-range access (per byte).

Behaviour:
- Reset: one clock `clk`; `reset` is asynchronous and active-low.
  - While reset is low: req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, err=0, state=IDLE, beat counter=0.
  - No RAM write occurs while reset is low. RAM contents are not cleared by reset.
  - Reset asserted mid-burst aborts the burst immediately; no partial beat is presented after release.
- States:
  - IDLE: req_ready=1, except in the first cycle after reset release, where it is 0.
  - RESP: streaming read beats.
- Handshake: a request is accepted on a posedge with req_valid & req_ready.
- Store accepted:
  - RAM[req_addr] <= req_wdata on that edge if req_addr < RAMSIZE; otherwise the store is dropped and err pulses next cycle.
  - No response beat. State stays IDLE and req_ready stays 1, so back-to-back stores are accepted every cycle.
- Read accepted:
  - Latch the address. N = BURST if req_burst else 1. Go to RESP.
  - Beat k (0..N-1) addresses (addr+k) mod 2^ADDRW.
- RESP:
  - rsp_valid=1 starting the cycle after acceptance (1-cycle latency).
  - rsp_data = RAM[beat addr], or 0x00 if beat addr >= RAMSIZE, with err pulsing for one cycle when that beat is first presented.
  - rsp_data and rsp_last are held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: advance k. rsp_last=1 on beat N-1. Its acceptance returns to IDLE, and req_ready=1 in the following cycle (no overlap of requests).
  - req_ready=0 throughout RESP.
- Ordering: a read immediately after a store to the same address returns the new data (the store commits on its accept edge, before the read samples).
- Wrap: a burst starting at RAMSIZE-2 returns RAM[62], RAM[63], then 0x00, 0x00 with err pulses on beats 2 and 3 (RAMSIZE=64).
- Address 0xFFFF burst: beats use 0xFFFF, 0x0000, 0x0001, 0x0002. The first beat is out of range; the others read RAM normally.
- Read data is registered from the array (synchronous-read compatible). Beat k+1 data is prefetched so that consecutive accepted beats sustain one beat per cycle.

Decomposition:
- Shared package (cpu_pkg):
  - RAMSIZE default.
  - BURST.
  - Opcode constants (MOV_CONST=1, MOV_LOAD=2, MOV_STORE=3, ADD=4).
  - Responder state enum {IDLE, RESP}.
- One sub-module, ram_array: single-port synchronous byte RAM, RAMSIZE x 8, with write enable and registered read. ram_responder contains only the handshake/beat FSM and range checks.

Test Plan:
- Reset then stores: release reset, store 0x02→0, 0x00→1, 0x10→2, 0x00→3 on consecutive cycles -> req_ready stays 1, no rsp_valid.
- Burst fetch at 0: rsp_valid on the cycle after accept; beats 0x02, 0x00, 0x10, 0x00; rsp_last only on beat 4; then req_ready=1 the following cycle.
- Backpressure: same fetch with rsp_ready low for 3 cycles on beat 2 -> rsp_data holds 0x00, rsp_valid holds 1, no beat skipped or repeated.
- Out-of-range: single load at 64 -> rsp_data=0x00, rsp_last=1, err one-cycle pulse. Store 0xAA to 70 -> err pulse, and RAM[6] is unchanged when read back.
- Boundary burst at 62 with RAM[62]=0x11, RAM[63]=0x22 -> 0x11, 0x22, 0x00, 0x00; err on beats 3 and 4 only.
- Reset mid-burst: assert reset low after beat 2 -> rsp_valid falls asynchronously. After release, the previously stored RAM[0..3] still reads 0x02, 0x00, 0x10, 0x00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core/memory constants: RAM geometry, fetch burst length, opcodes,
// and the responder state encoding.
package cpu_pkg;

  localparam int RAMSIZE = 64;
  localparam int BURST   = 4;

  localparam logic [7:0] MOV_CONST = 8'd1;
  localparam logic [7:0] MOV_LOAD  = 8'd2;
  localparam logic [7:0] MOV_STORE = 8'd3;
  localparam logic [7:0] ADD       = 8'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// Core <-> RAM responder request/response bundle; the core is the master and
// drives requests, the responder drives read beats, ready and err.
interface ram_responder_if #(
  parameter int ADDRW = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic             req_burst;
  logic [ADDRW-1:0] req_addr;
  logic [7:0]       req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_last;
  logic             err;

  modport master (
    output req_valid, req_write, req_burst, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, err
  );

  modport slave (
    input  req_valid, req_write, req_burst, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, err
  );
endinterface

// File: rtl/ram_array.sv
// Single-port DEPTH x 8 synchronous RAM; write on the enabled edge, read data
// registered one cycle after the address. Contents survive reset.
module ram_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Byte RAM responder: single-cycle stores, 1- or BURST-beat reads with one cycle
// of latency; beats hold under rsp_ready backpressure, one request at a time.
module ram_responder
  import cpu_pkg::*;
#(
  parameter int RAMSIZE = cpu_pkg::RAMSIZE,
  parameter int ADDRW   = 16,
  parameter int BURST   = cpu_pkg::BURST
) (
  input logic            clk,
  input logic            reset,
  ram_responder_if.slave bus
);

  localparam int AW = $clog2(RAMSIZE);
  localparam int KW = $clog2(BURST);
  localparam logic [ADDRW-1:0] RAM_LIMIT = ADDRW'(RAMSIZE);
  localparam logic [ADDRW-1:0] ADDR_ONE  = ADDRW'(1);
  localparam logic [KW-1:0]    K_LAST    = KW'(BURST - 1);
  localparam logic [KW-1:0]    K_ONE     = KW'(1);

  resp_state_t      state, state_nxt;
  logic             armed;
  logic             burst_q;
  logic             fresh;
  logic             err_st;
  logic [ADDRW-1:0] beat_addr;
  logic [KW-1:0]    beat_cnt;

  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_last;
  logic             accept;
  logic             beat_fire;
  logic             beat_in_range;
  logic             ram_we;
  logic             ram_hit;
  logic [ADDRW-1:0] ram_addr_full;
  logic [7:0]       ram_rdata;

  assign accept        = bus.req_valid & req_ready;
  assign beat_fire     = rsp_valid & bus.rsp_ready;
  assign beat_in_range = beat_addr < RAM_LIMIT;
  assign ram_hit       = ram_addr_full < RAM_LIMIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In RESP the array address runs one beat ahead whenever the current beat is
  // taken, so the next beat's data is registered in time for back-to-back beats.
  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_last      = 1'b0;
    ram_we        = 1'b0;
    ram_addr_full = bus.req_addr;
    unique case (state)
      IDLE: begin
        req_ready = armed;
        ram_we    = accept & bus.req_write & ram_hit;
        if (accept && !bus.req_write) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid     = 1'b1;
        rsp_last      = !burst_q || (beat_cnt == K_LAST);
        ram_addr_full = beat_fire ? beat_addr + ADDR_ONE : beat_addr;
        if (beat_fire && rsp_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      burst_q   <= 1'b0;
      fresh     <= 1'b0;
      err_st    <= 1'b0;
      beat_addr <= '0;
      beat_cnt  <= '0;
    end else begin
      armed  <= 1'b1;
      fresh  <= 1'b0;
      err_st <= 1'b0;
      if (accept) begin
        if (bus.req_write) begin
          err_st <= !ram_hit;
        end else begin
          beat_addr <= bus.req_addr;
          beat_cnt  <= '0;
          burst_q   <= bus.req_burst;
          fresh     <= 1'b1;
        end
      end else if (beat_fire && !rsp_last) begin
        beat_addr <= beat_addr + ADDR_ONE;
        beat_cnt  <= beat_cnt + K_ONE;
        fresh     <= 1'b1;
      end
    end
  end

  ram_array #(
    .DEPTH (RAMSIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr_full[AW-1:0]),
    .wdata (bus.req_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_last  = rsp_last;
  assign bus.rsp_data  = (rsp_valid && beat_in_range) ? ram_rdata : 8'h00;
  // fresh marks the first cycle a beat is shown, so a stalled bad beat pulses once.
  assign bus.err       = err_st | (fresh & rsp_valid & !beat_in_range);

endmodule

// File: tb/tb_ram_responder.sv
// Directed vector bench for ram_responder: table of stores/reads with expected
// beats and err pulses, plus hand sequences for reset behaviour.
module tb_ram_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ram_responder_if #(.ADDRW(16)) bus ();

  ram_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        wr;
    logic        bst;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [31:0] exp;
    logic [3:0]  errm;
    int          stall_beat;
    int          stall_n;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input string nm, input logic wr, input logic bst, input logic [15:0] addr,
                     input logic [7:0] wdata, input logic [31:0] exp, input logic [3:0] errm,
                     input int stall_beat, input int stall_n);
    vec_t v;
    v.nm = nm; v.wr = wr; v.bst = bst; v.addr = addr; v.wdata = wdata;
    v.exp = exp; v.errm = errm; v.stall_beat = stall_beat; v.stall_n = stall_n;
    tv.push_back(v);
  endtask

  task automatic do_store(input string nm, input logic [15:0] addr, input logic [7:0] wdata,
                          input logic exp_err);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_burst = 1'b0;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    chk({nm, " no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({nm, " err"}, 32'(bus.err), 32'(exp_err));
  endtask

  task automatic do_read(input string nm, input logic bst, input logic [15:0] addr,
                         input logic [31:0] exp, input logic [3:0] errm,
                         input int stall_beat, input int stall_n);
    int nb;
    nb = bst ? 4 : 1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_burst = bst;
    bus.req_addr  = addr;
    bus.rsp_ready = 1'b1;
    chk({nm, " ready"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < nb; k++) begin
      int smax;
      smax = (k == stall_beat) ? stall_n : 0;
      for (int s = 0; s <= smax; s++) begin
        chk($sformatf("%s b%0d valid", nm, k), 32'(bus.rsp_valid), 32'd1);
        chk($sformatf("%s b%0d data", nm, k), 32'(bus.rsp_data), 32'(exp[k*8 +: 8]));
        chk($sformatf("%s b%0d last", nm, k), 32'(bus.rsp_last), 32'(k == nb - 1));
        chk($sformatf("%s b%0d err", nm, k), 32'(bus.err), 32'(errm[k] && s == 0));
        chk($sformatf("%s b%0d busy", nm, k), 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = (s < smax) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
    end
    chk({nm, " done_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, " done_ready"}, 32'(bus.req_ready), 32'd1);
    chk({nm, " done_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_burst = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // expected beats packed as {beat3, beat2, beat1, beat0}; errm bit k = beat k
    add("st0",    1, 0, 16'd0,      8'h02, 32'h0, 4'b0000, -1, 0);
    add("st1",    1, 0, 16'd1,      8'h00, 32'h0, 4'b0000, -1, 0);
    add("st2",    1, 0, 16'd2,      8'h10, 32'h0, 4'b0000, -1, 0);
    add("st3",    1, 0, 16'd3,      8'h00, 32'h0, 4'b0000, -1, 0);
    add("fetch0", 0, 1, 16'd0,      8'h00, 32'h0010_0002, 4'b0000, -1, 0);
    add("bp0",    0, 1, 16'd0,      8'h00, 32'h0010_0002, 4'b0000, 1, 3);
    add("ld64",   0, 0, 16'd64,     8'h00, 32'h0, 4'b0001, -1, 0);
    add("st6",    1, 0, 16'd6,      8'h5A, 32'h0, 4'b0000, -1, 0);
    add("st70",   1, 0, 16'd70,     8'hAA, 32'h0, 4'b0001, -1, 0);
    add("ld6",    0, 0, 16'd6,      8'h00, 32'h0000_005A, 4'b0000, -1, 0);
    add("st62",   1, 0, 16'd62,     8'h11, 32'h0, 4'b0000, -1, 0);
    add("st63",   1, 0, 16'd63,     8'h22, 32'h0, 4'b0000, -1, 0);
    add("fetch62",0, 1, 16'd62,     8'h00, 32'h0000_2211, 4'b1100, -1, 0);
    add("st5",    1, 0, 16'd5,      8'h3C, 32'h0, 4'b0000, -1, 0);
    add("raw5",   0, 0, 16'd5,      8'h00, 32'h0000_003C, 4'b0000, -1, 0);
    add("fetchFF",0, 1, 16'hFFFF,   8'h00, 32'h1000_0200, 4'b0001, -1, 0);
    add("ld1bp",  0, 0, 16'd2,      8'h00, 32'h0000_0010, 4'b0000, 0, 2);

    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus.req_ready), 32'd0);
    chk("rst valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst data",  32'(bus.rsp_data),  32'd0);
    chk("rst last",  32'(bus.rsp_last),  32'd0);
    chk("rst err",   32'(bus.err),       32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst ready_first", 32'(bus.req_ready), 32'd0);
    @(negedge clk);

    foreach (tv[i]) begin
      if (tv[i].wr)
        do_store(tv[i].nm, tv[i].addr, tv[i].wdata, tv[i].errm[0]);
      else
        do_read(tv[i].nm, tv[i].bst, tv[i].addr, tv[i].exp, tv[i].errm,
                tv[i].stall_beat, tv[i].stall_n);
    end

    // Reset during beat index 2 of a fetch: response must vanish immediately.
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_burst = 1'b1;
    bus.req_addr  = 16'd0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid b0 data", 32'(bus.rsp_data), 32'h02);
    @(negedge clk);
    chk("mid b1 data", 32'(bus.rsp_data), 32'h00);
    @(negedge clk);
    chk("mid b2 valid", 32'(bus.rsp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid async valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid async data",  32'(bus.rsp_data),  32'd0);
    chk("mid async last",  32'(bus.rsp_last),  32'd0);
    chk("mid async ready", 32'(bus.req_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("mid held valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid rel ready_first", 32'(bus.req_ready), 32'd0);
    chk("mid rel valid",       32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("mid rel valid2", 32'(bus.rsp_valid), 32'd0);
    do_read("after_rst", 1'b1, 16'd0, 32'h0010_0002, 4'b0000, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
